// File: rtl/risk_pkg.sv
// Shared definitions for the risk unit: tile geometry, risk_func encodings,
// tile type and the tile writer FSM states.
package risk_pkg;

  localparam int SZ   = 3;
  localparam int BITS = 32;
  localparam int AW   = 17;
  localparam int SW   = 15;

  typedef enum logic [2:0] {
    RISK_NOP   = 3'b000,
    RISK_STORE = 3'b001,
    RISK_LOAD  = 3'b010
  } risk_func_t;

  typedef logic [SZ*SZ*BITS-1:0] tile_t;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_t;

endpackage

// File: rtl/risk_stride_agen.sv
// Strided tile address generator: walks x inner / y outer and produces
// base + x*stride_x + y*stride_y by accumulation (shared with the load path).
module risk_stride_agen #(
  parameter int SZ = risk_pkg::SZ,
  parameter int AW = risk_pkg::AW,
  parameter int SW = risk_pkg::SW,
  parameter int IW = $clog2(SZ*SZ)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [SW-1:0] stride_x,
  input  logic [SW-1:0] stride_y,
  output logic [IW-1:0] idx,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int CW = (SZ > 1) ? $clog2(SZ) : 1;

  logic [CW-1:0] x_reg, y_reg;
  logic [IW-1:0] idx_reg;
  logic [AW-1:0] row_reg, col_reg, sx_reg, sy_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_reg   <= '0;
      y_reg   <= '0;
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
      sx_reg  <= '0;
      sy_reg  <= '0;
    end else if (load) begin
      x_reg   <= '0;
      y_reg   <= '0;
      idx_reg <= '0;
      row_reg <= base;
      col_reg <= base;
      sx_reg  <= AW'(stride_x);
      sy_reg  <= AW'(stride_y);
    end else if (step) begin
      idx_reg <= idx_reg + IW'(1);
      if (x_reg == CW'(SZ-1)) begin
        // Row change: next column address starts from the new row origin.
        x_reg   <= '0;
        y_reg   <= y_reg + CW'(1);
        row_reg <= row_reg + sy_reg;
        col_reg <= row_reg + sy_reg;
      end else begin
        x_reg   <= x_reg + CW'(1);
        col_reg <= col_reg + sx_reg;
      end
    end
  end

  assign idx  = idx_reg;
  assign addr = col_reg;
  assign last = (x_reg == CW'(SZ-1)) && (y_reg == CW'(SZ-1));

endmodule

// File: rtl/risk_tile_writer.sv
// Strided tile store engine: scatters one SZxSZ tile to word-addressed memory,
// one element per granted cycle. Optional per-element mask: RISK_TILE_WRITER_MASK_EN.
module risk_tile_writer #(
  parameter int SZ   = risk_pkg::SZ,
  parameter int BITS = risk_pkg::BITS,
  parameter int AW   = risk_pkg::AW,
  parameter int SW   = risk_pkg::SW
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW-1:0]        cmd_base,
  input  logic [SW-1:0]        cmd_stride_x,
  input  logic [SW-1:0]        cmd_stride_y,
  input  logic [SZ*SZ*BITS-1:0] cmd_tile,
`ifdef RISK_TILE_WRITER_MASK_EN
  input  logic [SZ*SZ-1:0]     cmd_mask,
`endif
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  input  logic                 mem_gnt,
  output logic                 busy,
  output logic                 done
);

  import risk_pkg::*;

  localparam int NEL = SZ*SZ;
  localparam int IW  = $clog2(NEL);

  wr_state_t       state_reg;
  logic            ready_reg, busy_reg, done_reg, we_reg;
  logic [BITS-1:0] wdata_reg;
  logic [BITS-1:0] elem_reg [NEL];

  logic [IW-1:0]   idx, idx_next;
  logic            last, accept, advance, step;
  logic            first_we, next_we;

  assign accept   = (state_reg == ST_IDLE) && cmd_valid;
  // A masked-out slot (we_reg=0) advances without waiting for a grant.
  assign advance  = (state_reg == ST_WRITE) && (mem_gnt || !we_reg);
  assign step     = advance && !last;
  assign idx_next = idx + IW'(1);

`ifdef RISK_TILE_WRITER_MASK_EN
  logic [NEL-1:0] mask_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     mask_reg <= '0;
    else if (accept) mask_reg <= cmd_mask;
  end

  assign first_we = cmd_mask[0];
  assign next_we  = mask_reg[idx_next];
`else
  assign first_we = 1'b1;
  assign next_we  = 1'b1;
`endif

  risk_stride_agen #(.SZ(SZ), .AW(AW), .SW(SW), .IW(IW)) u_agen (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .step     (step),
    .base     (cmd_base),
    .stride_x (cmd_stride_x),
    .stride_y (cmd_stride_y),
    .idx      (idx),
    .addr     (mem_addr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NEL; i++) elem_reg[i] <= cmd_tile[i*BITS +: BITS];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_reg <= ST_WRITE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            we_reg    <= first_we;
            wdata_reg <= cmd_tile[BITS-1:0];
          end
        end
        ST_WRITE: begin
          if (advance) begin
            if (last) begin
              state_reg <= ST_IDLE;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b0;
              we_reg    <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              we_reg    <= next_we;
              wdata_reg <= elem_reg[idx_next];
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_we    = we_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_risk_tile_writer.sv
// Scoreboard bench for risk_tile_writer: expected writes come from the address
// formula base + x*sx + y*sy; a monitor checks every granted write and done.
module tb_risk_tile_writer;
  import risk_pkg::*;

  localparam int NEL = SZ*SZ;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_base = '0;
  logic [SW-1:0]   cmd_stride_x = '0;
  logic [SW-1:0]   cmd_stride_y = '0;
  tile_t           cmd_tile = '0;
`ifdef RISK_TILE_WRITER_MASK_EN
  logic [NEL-1:0]  cmd_mask = '1;
`endif
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [BITS-1:0] mem_wdata;
  logic            mem_gnt = 1'b0;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  risk_tile_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_stride_x (cmd_stride_x),
    .cmd_stride_y (cmd_stride_y),
    .cmd_tile     (cmd_tile),
`ifdef RISK_TILE_WRITER_MASK_EN
    .cmd_mask     (cmd_mask),
`endif
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [AW-1:0]   a;
    logic [BITS-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_n_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  grants = 0, wr_since_done = 0, done_count = 0;
  int  last_done_cyc = 0, first_wr_cyc = 0;
  int  gnt_mode = 0, stall_target = -1, stall_left = 0;
  logic            prev_stall = 1'b0;
  logic [AW-1:0]   prev_addr = '0;
  logic [BITS-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant driver: tied high, random, or a directed stall on a chosen element.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && grants == stall_target) begin
        mem_gnt = 1'b0;
        stall_left--;
      end else if (gnt_mode == 0) mem_gnt = 1'b1;
      else mem_gnt = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("busy_vs_ready", {63'd0, busy}, {63'd0, !cmd_ready});
        if (prev_stall) begin
          chk("stall_we", {63'd0, mem_we}, 64'd1);
          chk("stall_addr", 64'(mem_addr), 64'(prev_addr));
          chk("stall_data", 64'(mem_wdata), 64'(prev_data));
        end
        if (mem_we && mem_gnt) begin
          if (exp_q.size() == 0) begin
            chk("spurious_write", 64'(mem_addr), 64'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.a));
            chk("wr_data", 64'(mem_wdata), 64'(e.d));
            $display("write addr=%05h data=%08h cyc=%0d", mem_addr, mem_wdata, cyc);
          end
          if (wr_since_done == 0) first_wr_cyc = cyc;
          wr_since_done++;
          grants++;
        end
        prev_stall = mem_we && !mem_gnt;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
        if (done) begin
          chk("done_idle", {62'd0, mem_we, !cmd_ready}, 64'd0);
          done_count++;
          last_done_cyc = cyc;
          if (exp_n_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else chk("writes_per_cmd", 64'(wr_since_done), 64'(exp_n_q.pop_front()));
          wr_since_done = 0;
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] b, input logic [SW-1:0] sx, input logic [SW-1:0] sy,
                      input tile_t t, input logic [NEL-1:0] m, output int acc_cyc);
    int n = 0;
    int to = 0;
    for (int y = 0; y < SZ; y++) begin
      for (int x = 0; x < SZ; x++) begin
        int k = y*SZ + x;
        if (m[k]) begin
          wr_t e;
          e.a = AW'(int'(b) + x*int'(sx) + y*int'(sy));
          e.d = t[k*BITS +: BITS];
          exp_q.push_back(e);
          n++;
        end
      end
    end
    exp_n_q.push_back(n);
    @(negedge clk);
    while (!cmd_ready && to < 500) begin
      @(negedge clk);
      to++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid    = 1'b1;
    cmd_base     = b;
    cmd_stride_x = sx;
    cmd_stride_y = sy;
    cmd_tile     = t;
`ifdef RISK_TILE_WRITER_MASK_EN
    cmd_mask     = m;
`endif
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    // Scramble inputs: the accepted command must be latched.
    cmd_base     = AW'($urandom);
    cmd_stride_x = SW'($urandom);
    cmd_stride_y = SW'($urandom);
    for (int k = 0; k < NEL; k++) cmd_tile[k*BITS +: BITS] = $urandom;
    $display("cmd base=%05h sx=%0d sy=%0d mask=%0h accepted cyc=%0d writes=%0d", b, sx, sy, m, acc_cyc, n);
  endtask

  task automatic wait_done(input int target);
    int to = 0;
    while (done_count < target && to < 3000) begin
      @(negedge clk);
      to++;
    end
    chk("done_wait", 64'(done_count >= target), 64'd1);
  endtask

  task automatic ramp_tile(input int base_val, output tile_t t);
    for (int k = 0; k < NEL; k++) t[k*BITS +: BITS] = BITS'(base_val + k);
  endtask

  initial begin
    tile_t t;
    int acc, acc2, g0, dc, to;
    logic [NEL-1:0] full;
    full = '1;

    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_outs", {60'd0, mem_we, busy, done, 1'b0}, 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Basic: addresses 0..8, data = element index, done NEL cycles after accept.
    gnt_mode = 0;
    ramp_tile(0, t);
    send(17'd0, 15'd1, 15'd3, t, full, acc);
    wait_done(1);
    chk("basic_first_wr", 64'(first_wr_cyc - acc), 64'd0);
    chk("basic_done_lat", 64'(last_done_cyc - acc), 64'(NEL));

    // Transposed strides.
    ramp_tile(32'h100, t);
    send(17'd100, 15'd3, 15'd1, t, full, acc);
    wait_done(2);

    // Backpressure: four stalled cycles on element 4.
    ramp_tile(32'h200, t);
    stall_target = grants + 4;
    stall_left   = 4;
    send(17'd40, 15'd2, 15'd10, t, full, acc);
    wait_done(3);
    chk("stall_done_lat", 64'(last_done_cyc - acc), 64'(NEL + 4));

    // Wrap at 2^AW and back-to-back acceptance in the done cycle.
    ramp_tile(32'h300, t);
    send(17'h1FFFE, 15'd1, 15'd3, t, full, acc);
    ramp_tile(32'h400, t);
    send(17'd7, 15'd5, 15'd100, t, full, acc2);
    wait_done(5);
    chk("b2b_accept", 64'(acc2 - acc), 64'(NEL + 1));
    chk("b2b_first_wr", 64'(first_wr_cyc - acc2), 64'd0);
    chk("b2b_done_lat", 64'(last_done_cyc - acc2), 64'(NEL));

    // Zero strides: every write hits base.
    ramp_tile(32'h500, t);
    send(17'd1234, 15'd0, 15'd0, t, full, acc);
    wait_done(6);

    // Reset mid-operation after the 5th grant.
    ramp_tile(32'h600, t);
    g0 = grants;
    send(17'd9, 15'd1, 15'd3, t, full, acc);
    to = 0;
    while (grants < g0 + 5 && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("rst_mid_grants", 64'(grants - g0), 64'd5);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_ready", {63'd0, cmd_ready}, 64'd1);
    chk("abort_outs", {61'd0, mem_we, busy, done}, 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    chk("abort_wdata", 64'(mem_wdata), 64'd0);
    exp_q.delete();
    exp_n_q.delete();
    wr_since_done = 0;
    prev_stall = 1'b0;
    dc = done_count;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", 64'(done_count), 64'(dc));
    ramp_tile(32'h700, t);
    send(17'd9, 15'd1, 15'd3, t, full, acc);
    wait_done(dc + 1);
    chk("post_rst_done_lat", 64'(last_done_cyc - acc), 64'(NEL));

`ifdef RISK_TILE_WRITER_MASK_EN
    ramp_tile(32'h800, t);
    send(17'd50, 15'd2, 15'd7, t, 9'b101010101, acc);
    wait_done(done_count + 1);
    chk("mask_done_lat", 64'(last_done_cyc - acc), 64'(NEL));
    send(17'd60, 15'd1, 15'd3, t, '0, acc);
    wait_done(done_count + 1);
    chk("mask0_done_lat", 64'(last_done_cyc - acc), 64'(NEL));
`endif

    // Randomized commands with random grants, issued back-to-back.
    gnt_mode = 1;
    dc = done_count;
    for (int i = 0; i < 25; i++) begin
      logic [SW-1:0] sx, sy;
      logic [NEL-1:0] m;
      sx = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
      sy = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
      for (int k = 0; k < NEL; k++) t[k*BITS +: BITS] = $urandom;
`ifdef RISK_TILE_WRITER_MASK_EN
      m = NEL'($urandom);
`else
      m = full;
`endif
      send(AW'($urandom), sx, sy, t, m, acc);
    end
    wait_done(dc + 25);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("cmds_outstanding", 64'(exp_n_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
